// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I pipeline constants and the IF/ID bundle type
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush (bubble) and stall (hold)
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    // flush outranks stall so a taken branch always squashes the wrong-path fetch
    always_ff @(posedge clk) begin
        if (reset || flush_i) q_q <= IF_ID_BUBBLE;
        else if (!stall_i)    q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC selection and IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               if_id_valid,
    output logic [XLEN-1:0]    if_id_pc,
    output logic [XLEN-1:0]    if_id_pc_plus4,
    output logic [31:0]        if_id_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    if_id_t          fetch_d, if_id_q;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign fetch_d   = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_plus4, instr: imem_rdata};

    // redirect beats stall; redirect targets are forced word-aligned
    always_comb begin
        pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : stall ? pc_q : pc_plus4;
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .flush_i (redirect_valid),
        .d_i     (fetch_d),
        .q_o     (if_id_q)
    );

    assign if_id_valid    = if_id_q.valid;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;
    logic        fetch_inc, stall_inc;

    assign fetch_inc = !redirect_valid && !stall;
    assign stall_inc = !redirect_valid && stall;

    // saturating event counters, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_inc && ~&fetch_cnt_q)      fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_inc && ~&stall_cnt_q)      stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_valid && ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed checks of fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h0010_0093 + {24'h0, imem_addr};

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rv;
        logic [31:0] rpc;
        logic [7:0]  addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] ins;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset          = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] a, input logic v,
                           input logic [31:0] pc, input logic [31:0] p4, input logic [31:0] ins);
        chk({tag, " imem_addr"}, {24'h0, imem_addr}, {24'h0, a});
        chk({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, v});
        chk({tag, " pc"}, if_id_pc, pc);
        chk({tag, " pc_plus4"}, if_id_pc_plus4, p4);
        chk({tag, " instr"}, if_id_instr, ins);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        //            rst   stl   rv    rpc            addr   v     pc             p4             instr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h01, 1'b1, 32'h0,         32'h4,         32'h0010_0093};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h02, 1'b1, 32'h4,         32'h8,         32'h0010_0094};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h02, 1'b1, 32'h4,         32'h8,         32'h0010_0094};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h02, 1'b1, 32'h4,         32'h8,         32'h0010_0094};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h02, 1'b1, 32'h4,         32'h8,         32'h0010_0094};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h03, 1'b1, 32'h8,         32'hC,         32'h0010_0095};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h40,       8'h10, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h11, 1'b1, 32'h40,        32'h44,        32'h0010_00A3};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h23,       8'h08, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h100,      8'h40, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h104,      8'h41, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h42, 1'b1, 32'h104,       32'h108,       32'h0010_00D4};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 8'hFF, 1'b0, 32'h0,        32'h0,         32'h13};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h00, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0010_0192};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h01, 1'b1, 32'h0,         32'h4,         32'h0010_0093};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        8'h01, 1'b1, 32'h0,         32'h4,         32'h0010_0093};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 32'h80,       8'h00, 1'b0, 32'h0,         32'h0,         32'h13};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,        8'h01, 1'b1, 32'h0,         32'h4,         32'h0010_0093};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rpc);
            chk_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].v, vecs[i].pc, vecs[i].p4, vecs[i].ins);
`ifdef FETCH_PERF_CNT_EN
            if (i == 16) begin
                chk("perf_fetch", perf_fetch_cnt, 32'd7);
                chk("perf_stall", perf_stall_cnt, 32'd4);
                chk("perf_flush", perf_flush_cnt, 32'd5);
            end
            if (i == 17 || i == 18) begin
                chk($sformatf("vec%0d perf_fetch_rst", i), perf_fetch_cnt, 32'd0);
                chk($sformatf("vec%0d perf_stall_rst", i), perf_stall_cnt, 32'd0);
                chk($sformatf("vec%0d perf_flush_rst", i), perf_flush_cnt, 32'd0);
            end
`endif
        end

        // redirect directly into a two-cycle stall: bubble must persist, then 0x200 then 0x204 follow
        step(1'b0, 1'b0, 1'b1, 32'h200);
        chk_out("seq redirect", 8'h80, 1'b0, 32'h0, 32'h0, 32'h13);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_out("seq stall1", 8'h80, 1'b0, 32'h0, 32'h0, 32'h13);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_out("seq stall2", 8'h80, 1'b0, 32'h0, 32'h0, 32'h13);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_out("seq run1", 8'h81, 1'b1, 32'h200, 32'h204, 32'h0010_0113);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk_out("seq stall3", 8'h81, 1'b1, 32'h200, 32'h204, 32'h0010_0113);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_out("seq run2", 8'h82, 1'b1, 32'h204, 32'h208, 32'h0010_0114);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
